// File: rtl/game_pkg.sv
// Shared types and constants for the pipe scheduler and its slot registers.
package game_pkg;

    localparam int COORD_W         = 10;
    localparam int SCREEN_WIDTH_PX = 640;
    localparam int PIPE_WIDTH_PX   = 50;
    localparam int BIRD_X_PX       = 100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        DONE
    } scan_state_t;

    // Adds two 8-bit values and clamps the result at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipe slot: position, gap height, occupancy and the passed-the-bird flag.
module pipe_slot
    import game_pkg::*;
#(
    parameter int SCREEN_WIDTH = SCREEN_WIDTH_PX,
    parameter int PIPE_WIDTH   = PIPE_WIDTH_PX,
    parameter int BIRD_X       = BIRD_X_PX,
    parameter int SPEED        = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic               frame_tick,
    input  logic               load,
    input  logic [COORD_W-1:0] gap_y,
    output logic               active,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               score_hit
);

    localparam int SUM_W = COORD_W + 1;

    logic scored;

    // The right edge is compared one bit wider so x+PIPE_WIDTH cannot wrap.
    assign score_hit = enable && !clear && active && !scored &&
                       (({1'b0, x} + SUM_W'(PIPE_WIDTH)) < SUM_W'(BIRD_X));

    // Spawn load, leftward motion with retirement, and the scored flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
            scored <= 1'b0;
        end else if (clear) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
            scored <= 1'b0;
        end else if (enable) begin
            if (load) begin
                active <= 1'b1;
                x      <= COORD_W'(SCREEN_WIDTH);
                y      <= gap_y;
                scored <= 1'b0;
            end else begin
                if (frame_tick && active) begin
                    if (x < COORD_W'(SPEED))
                        active <= 1'b0;
                    else
                        x <= x - COORD_W'(SPEED);
                end
                if (score_hit)
                    scored <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe scheduler: spawns pipes into free slots, keeps score and walks the
// active slots through an external collision checker once per frame.
module pipe_scheduler
    import game_pkg::*;
#(
    parameter int NUM_SLOTS      = 3,
    parameter int SCREEN_WIDTH   = SCREEN_WIDTH_PX,
    parameter int PIPE_WIDTH     = PIPE_WIDTH_PX,
    parameter int BIRD_X         = BIRD_X_PX,
    parameter int SPEED          = 2,
    parameter int SPAWN_INTERVAL = 120
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         frame_tick,
    input  logic [COORD_W-1:0]           gap_y_in,
    input  logic                         chk_hit,
    output logic                         chk_valid,
    output logic [COORD_W-1:0]           chk_x,
    output logic [COORD_W-1:0]           chk_y,
    output logic [NUM_SLOTS-1:0]         pipe_active,
    output logic [NUM_SLOTS*COORD_W-1:0] pipe_x,
    output logic [NUM_SLOTS*COORD_W-1:0] pipe_y,
    output logic [7:0]                   score,
    output logic                         collision,
    output logic                         spawn_drop
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

    logic [COORD_W-1:0] slot_x [NUM_SLOTS];
    logic [COORD_W-1:0] slot_y [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] load_vec;
    logic [NUM_SLOTS-1:0] score_vec;
    logic [CNT_W-1:0] spawn_cnt;
    logic spawn_now;
    logic [7:0] pass_count;

    scan_state_t state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic hit_acc, hit_n;
    logic req_issued, issued_n;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        pipe_slot #(
            .SCREEN_WIDTH(SCREEN_WIDTH),
            .PIPE_WIDTH  (PIPE_WIDTH),
            .BIRD_X      (BIRD_X),
            .SPEED       (SPEED)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .clear     (clear),
            .frame_tick(frame_tick),
            .load      (load_vec[i]),
            .gap_y     (gap_y_in),
            .active    (pipe_active[i]),
            .x         (slot_x[i]),
            .y         (slot_y[i]),
            .score_hit (score_vec[i])
        );
        assign pipe_x[i*COORD_W +: COORD_W] = slot_x[i];
        assign pipe_y[i*COORD_W +: COORD_W] = slot_y[i];
    end

    assign spawn_now = enable && !clear && frame_tick &&
                       (spawn_cnt == CNT_W'(SPAWN_INTERVAL - 1));

    // Pick the lowest-index slot that is free before this tick's retirements.
    always_comb begin
        load_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (spawn_now && !pipe_active[i] && (load_vec == '0))
                load_vec[i] = 1'b1;
        end
    end

    // Number of slots passing the bird in this cycle.
    always_comb begin
        pass_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            pass_count = pass_count + 8'(score_vec[i]);
    end

    // Spawn interval counter, saturating score and the no-free-slot pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spawn_cnt  <= '0;
            score      <= '0;
            spawn_drop <= 1'b0;
        end else if (clear) begin
            spawn_cnt  <= '0;
            score      <= '0;
            spawn_drop <= 1'b0;
        end else begin
            spawn_drop <= spawn_now && (pipe_active == '1);
            if (enable) begin
                score <= sat_add8(score, pass_count);
                if (frame_tick)
                    spawn_cnt <= (spawn_cnt == CNT_W'(SPAWN_INTERVAL - 1)) ? '0 : spawn_cnt + 1'b1;
            end
        end
    end

    // Scan state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            hit_acc    <= 1'b0;
            req_issued <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            hit_acc    <= hit_n;
            req_issued <= issued_n;
        end
    end

    // Scan next-state and checker strobes; a frame tick always restarts the walk.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        hit_n     = hit_acc;
        issued_n  = req_issued;
        chk_valid = 1'b0;
        collision = 1'b0;
        if (clear) begin
            state_n  = IDLE;
            idx_n    = '0;
            hit_n    = 1'b0;
            issued_n = 1'b0;
        end else if (enable) begin
            if (state == ISSUE)
                chk_valid = pipe_active[idx];
            if (state == DONE)
                collision = hit_acc;
            if (frame_tick) begin
                state_n  = ISSUE;
                idx_n    = '0;
                hit_n    = 1'b0;
                issued_n = 1'b0;
            end else begin
                case (state)
                    IDLE: state_n = IDLE;
                    ISSUE: begin
                        issued_n = pipe_active[idx];
                        state_n  = RESP;
                    end
                    RESP: begin
                        if (req_issued && chk_hit)
                            hit_n = 1'b1;
                        if (idx == IDX_W'(NUM_SLOTS - 1)) begin
                            idx_n   = '0;
                            state_n = DONE;
                        end else begin
                            idx_n   = idx + 1'b1;
                            state_n = ISSUE;
                        end
                    end
                    DONE: begin
                        hit_n   = 1'b0;
                        state_n = IDLE;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    assign chk_x = chk_valid ? slot_x[idx] : '0;
    assign chk_y = chk_valid ? slot_y[idx] : '0;

endmodule
